fifo_dosbits: RTL and testbench
===============================

FIFO_DOSBITS -- requirements
Module: fifo_dosbits

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, number of 2-bit entries (power of two, 2..16).
REQ-002 The module SHALL have parameter AF_TH, default 3, almost-full occupancy threshold.
REQ-003 The module SHALL have parameter AE_TH, default 1, almost-empty occupancy threshold.
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port reset_L  input  1  asynchronous, active-low reset.
REQ-006 Port valid_in  input  1  push strobe, driven by upstream mux validout.
REQ-007 Port data_in  input  2  write data, driven by upstream mux data output.
REQ-008 Port pop  input  1  read request from consumer.
REQ-009 Port data_out  output  2  registered read data.
REQ-010 Port valid_out  output  1  data_out carries a newly popped word this cycle.
REQ-011 Port full / empty  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-012 Port count  output  clog2(DEPTH)+1  current occupancy.
REQ-013 Port error  output  1  sticky overflow/underflow flag.
REQ-014 Ports almost_full / almost_empty  output  1 each  present only under FIFO_ALMOST_FLAGS_EN.

Function
REQ-015 Storage SHALL be DEPTH x 2-bit array with wrapping write and read pointers; pointers wrap DEPTH-1 -> 0.
REQ-016 Push accepted when valid_in=1 and (full=0 or pop=1); word written at wr_ptr, wr_ptr+1.
REQ-017 Pop accepted when pop=1 and empty=0; head word registered to data_out and valid_out=1 on the following edge (1-cycle read latency).
REQ-018 When no pop is accepted, valid_out SHALL be 0 and data_out SHALL hold its last value.
REQ-019 Simultaneous accepted push and pop SHALL leave count unchanged; when full both SHALL succeed.
REQ-020 Push+pop when empty: push stored, pop ignored (no bypass), valid_out=0, no error.
REQ-021 Push when full without pop SHALL drop the word, leave state unchanged, and set error.
REQ-022 Pop when empty (without push) SHALL be ignored and set error.
REQ-023 error SHALL stay 1 until reset; it SHALL NOT block further operation.
REQ-024 full, empty, count, almost flags SHALL be derived from registered state (valid same cycle as count).
REQ-025 Word order SHALL be strict FIFO; no word duplicated or reordered across wrap-around.

Reset
REQ-026 reset_L=0 SHALL immediately, without clk, clear pointers, count=0, data_out=2'b00, valid_out=0, error=0, full=0, empty=1.
REQ-027 Array contents need not be cleared; they SHALL never be visible before being written.
REQ-028 Reset asserted mid-operation SHALL discard all stored words; first post-reset pop on empty SHALL set error.
REQ-029 Push/pop SHALL be ignored on the first edge where reset_L is low.

Configuration
REQ-030 With FIFO_ALMOST_FLAGS_EN defined: almost_full=1 iff count >= AF_TH; almost_empty=1 iff count <= AE_TH; both reset to 0 and 1 respectively.
REQ-031 Without FIFO_ALMOST_FLAGS_EN: almost_full/almost_empty ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset then push 2'b01,2'b10,2'b11 on consecutive cycles, then pop x3 -> data_out 01,10,11 each one cycle after pop, valid_out=1 each, empty=1 after, error=0.
REQ-033 Push 5 words into DEPTH=4 with no pop -> full=1 after 4th, 5th dropped, error=1, count=4; pops return the first 4 words.
REQ-034 Fill to full, then push 2'b10 with pop same cycle -> count stays 4, oldest word out, 2'b10 read last; no error.
REQ-035 Pop on empty after reset -> valid_out=0, data_out=00, error=1; push+pop on empty -> count=1, valid_out=0.
REQ-036 Push 3 words, assert reset_L=0 between clock edges -> outputs cleared immediately, count=0, empty=1, error=0.
REQ-037 With FIFO_ALMOST_FLAGS_EN, fill 0->4 then drain -> almost_full=1 at count 3,4; almost_empty=1 at count 0,1.

Source files
------------

// File: rtl/fifo_dosbits.sv
// Small 2-bit-wide synchronous FIFO with registered read data and a sticky overflow/underflow flag.
// Optional almost_full/almost_empty outputs are built only when FIFO_ALMOST_FLAGS_EN is defined.
module fifo_dosbits #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AF_TH = 3,
  parameter int unsigned AE_TH = 1
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    valid_in,
  input  logic [1:0]              data_in,
  input  logic                    pop,
  output logic [1:0]              data_out,
  output logic                    valid_out,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    error
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                    almost_full,
  output logic                    almost_empty
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Elaboration-time guard on the configuration space
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      AF_TH > DEPTH || AE_TH > DEPTH) begin : g_param_check
    $error("fifo_dosbits: illegal DEPTH/AF_TH/AE_TH combination");
  end

  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             push_ok_c;
  logic             pop_ok_c;
  logic             err_set_c;
  logic [CNT_W-1:0] count_nxt_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Acceptance: a full FIFO takes a push only alongside a pop; an empty FIFO never pops
  always_comb begin
    push_ok_c   = 1'b0;
    pop_ok_c    = 1'b0;
    err_set_c   = 1'b0;
    count_nxt_c = count;

    pop_ok_c  = pop && !empty;
    push_ok_c = valid_in && (!full || pop);
    err_set_c = (valid_in && full && !pop) || (pop && empty && !valid_in);

    count_nxt_c = CNT_W'(count + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c));
  end

  // Storage array carries no reset; read pointer logic keeps stale entries invisible
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      data_out  <= 2'b00;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (push_ok_c) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok_c) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        data_out <= mem[rd_ptr];
      end
      valid_out <= pop_ok_c;
      count     <= count_nxt_c;
      full      <= (count_nxt_c == CNT_W'(DEPTH));
      empty     <= (count_nxt_c == '0);
      if (err_set_c) begin
        error <= 1'b1;
      end
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  // Threshold flags follow the registered occupancy
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (32'(count_nxt_c) >= AF_TH);
      almost_empty <= (32'(count_nxt_c) <= AE_TH);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_dosbits.sv
// Self-checking bench for fifo_dosbits: directed vector table, corner-case sequences,
// and a randomized run against a queue-based reference model.
module tb_fifo_dosbits;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF_TH = 3;
  localparam int unsigned AE_TH = 1;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset_L;
  logic          valid_in;
  logic [1:0]    data_in;
  logic          pop;
  logic [1:0]    data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          error;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  int checks = 0;
  int errors = 0;

  fifo_dosbits #(.DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .pop       (pop),
    .data_out  (data_out),
    .valid_out (valid_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .error     (error)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic       p;
    logic [1:0] edo;
    logic       ev;
    int         ecnt;
    logic       efull;
    logic       eempty;
    logic       eerr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] edo, input logic ev,
                         input int ecnt, input logic efull, input logic eempty,
                         input logic eerr);
    chk({tag, ".data_out"},  int'(data_out),  int'(edo));
    chk({tag, ".valid_out"}, int'(valid_out), int'(ev));
    chk({tag, ".count"},     int'(count),     ecnt);
    chk({tag, ".full"},      int'(full),      int'(efull));
    chk({tag, ".empty"},     int'(empty),     int'(eempty));
    chk({tag, ".error"},     int'(error),     int'(eerr));
`ifdef FIFO_ALMOST_FLAGS_EN
    chk({tag, ".almost_full"},  int'(almost_full),  int'(ecnt >= int'(AF_TH)));
    chk({tag, ".almost_empty"}, int'(almost_empty), int'(ecnt <= int'(AE_TH)));
`endif
  endtask

  task automatic step(input logic v, input logic [1:0] d, input logic p);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    pop      = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L  = 1'b0;
    valid_in = 1'b0;
    pop      = 1'b0;
    data_in  = 2'b00;
    @(negedge clk);
    reset_L  = 1'b1;
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] d, input logic p,
                              input logic [1:0] edo, input logic ev, input int ecnt,
                              input logic efull, input logic eempty, input logic eerr);
    vec_t r;
    r.v = v; r.d = d; r.p = p; r.edo = edo; r.ev = ev; r.ecnt = ecnt;
    r.efull = efull; r.eempty = eempty; r.eerr = eerr;
    return r;
  endfunction

  logic [1:0] q[$];
  logic [1:0] m_dout;
  logic       m_err;
  logic       m_v;

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 2'b00;
    pop      = 1'b0;

    // In-order drain, refill across the wrap point, push+pop while full
    tbl.push_back(mk(1, 2'b01, 0, 2'b00, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 2'b00, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 2'b00, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 2'b01, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 2'b10, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 2'b11, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0, 2'b11, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 2'b00, 0, 2'b11, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 2'b01, 0, 2'b11, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 2'b11, 0, 3, 0, 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 2'b11, 0, 4, 1, 0, 0));
    tbl.push_back(mk(1, 2'b10, 1, 2'b00, 1, 4, 1, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 2'b01, 1, 3, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 2'b10, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 2'b11, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 2'b10, 1, 0, 0, 1, 0));

    #12;
    chk_all("reset", 2'b00, 0, 0, 0, 1, 0);
    do_reset();

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].p);
      chk_all($sformatf("vec%0d", i), tbl[i].edo, tbl[i].ev, tbl[i].ecnt,
              tbl[i].efull, tbl[i].eempty, tbl[i].eerr);
    end

    // Overflow: fifth push is dropped, first four words survive
    do_reset();
    step(1, 2'b01, 0);
    step(1, 2'b10, 0);
    step(1, 2'b11, 0);
    step(1, 2'b00, 0);
    chk_all("ovf.fill", 2'b00, 0, 4, 1, 0, 0);
    step(1, 2'b01, 0);
    chk_all("ovf.drop", 2'b00, 0, 4, 1, 0, 1);
    step(0, 2'b00, 1);
    chk_all("ovf.pop0", 2'b01, 1, 3, 0, 0, 1);
    step(0, 2'b00, 1);
    chk_all("ovf.pop1", 2'b10, 1, 2, 0, 0, 1);
    step(0, 2'b00, 1);
    chk_all("ovf.pop2", 2'b11, 1, 1, 0, 0, 1);
    step(0, 2'b00, 1);
    chk_all("ovf.pop3", 2'b00, 1, 0, 0, 1, 1);

    // Underflow, then push+pop on empty (no bypass), error stays sticky
    do_reset();
    step(0, 2'b00, 1);
    chk_all("udf.pop", 2'b00, 0, 0, 0, 1, 1);
    step(1, 2'b11, 1);
    chk_all("udf.pushpop", 2'b00, 0, 1, 0, 0, 1);
    step(1, 2'b01, 0);
    step(1, 2'b10, 0);
    step(0, 2'b00, 1);
    chk_all("udf.pop11", 2'b11, 1, 2, 0, 0, 1);

    // Asynchronous reset between edges clears everything at once
    #2;
    reset_L = 1'b0;
    #1;
    chk_all("async_rst", 2'b00, 0, 0, 0, 1, 0);
    step(1, 2'b10, 1);
    chk_all("rst_edge_ignored", 2'b00, 0, 0, 0, 1, 0);
    @(negedge clk);
    reset_L  = 1'b1;
    valid_in = 1'b0;
    pop      = 1'b0;
    step(0, 2'b00, 1);
    chk_all("post_rst_pop", 2'b00, 0, 0, 0, 1, 1);

    // Randomized traffic against a queue model
    do_reset();
    q.delete();
    m_dout = 2'b00;
    m_err  = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic       rv;
      logic [1:0] rd;
      logic       rp;
      logic       m_full;
      logic       m_empty;
      rv = 1'($urandom_range(0, 1));
      rd = 2'($urandom_range(0, 3));
      rp = 1'($urandom_range(0, 1));
      m_full  = (q.size() == DEPTH);
      m_empty = (q.size() == 0);
      m_v = 1'b0;
      if (rp && !m_empty) begin
        m_dout = q.pop_front();
        m_v    = 1'b1;
      end
      if (rv && (!m_full || rp)) q.push_back(rd);
      if ((rv && m_full && !rp) || (rp && m_empty && !rv)) m_err = 1'b1;
      step(rv, rd, rp);
      chk_all($sformatf("rnd%0d", n), m_dout, m_v, q.size(),
              q.size() == DEPTH, q.size() == 0, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
